// File: rtl/vit_pkg.sv
// Shared trellis definitions for the K=3, rate-1/2 (octal 7,6) convolutional code.
// Used by both the encoder and the Viterbi decoder so their code definitions cannot drift.
package vit_pkg;

  localparam int unsigned NUM_STATES   = 4;
  localparam int unsigned K            = 3;
  localparam logic [2:0]  G0           = 3'b111;
  localparam logic [2:0]  G1           = 3'b110;
  localparam int unsigned PM_W_DEFAULT = 4;

  typedef logic [PM_W_DEFAULT-1:0] pm_t;

  // Shift register is {b, s1, s2}; each generator taps it MSB-first.
  function automatic logic [1:0] expected_sym(input logic [1:0] state, input logic b);
    logic [2:0] sr;
    sr = {b, state};
    return {^(sr & G0), ^(sr & G1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] d;
    d = a ^ b;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

endpackage

// File: rtl/vit_acs.sv
// Single-state add-compare-select: picks the cheaper of two predecessor paths.
// Ties resolve to predecessor 0.
module vit_acs #(
  parameter int unsigned PM_W = 4
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [1:0]      bm0_i,
  input  logic [1:0]      bm1_i,
  output logic [PM_W:0]   cand_o,
  output logic            dec_o
);

  logic [PM_W:0] cand0;
  logic [PM_W:0] cand1;

  // One extra bit so metric + branch cost never wraps before normalisation.
  assign cand0  = {1'b0, pm0_i} + {{(PM_W - 1){1'b0}}, bm0_i};
  assign cand1  = {1'b0, pm1_i} + {{(PM_W - 1){1'b0}}, bm1_i};
  assign dec_o  = (cand1 < cand0);
  assign cand_o = dec_o ? cand1 : cand0;

endmodule

// File: rtl/vdecoder.sv
// Hard-decision Viterbi decoder for the K=3 rate-1/2 code: 4-state ACS with
// min-normalised metrics and register-exchange survivors of DEPTH bits.
module vdecoder
  import vit_pkg::*;
#(
  parameter int unsigned DEPTH   = 15,
  parameter int unsigned PM_W    = PM_W_DEFAULT,
  parameter int unsigned INIT_PM = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  input  logic in_valid_i,
  input  logic in_i,
  output logic out_valid_o,
  output logic out_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             phase_q;
  logic             g0_q;
  logic [PM_W-1:0]  pm_q   [NUM_STATES];
  logic [DEPTH-1:0] surv_q [NUM_STATES];
  logic [CNT_W-1:0] cnt_q;
  logic             out_q;
  logic             out_valid_q;

  logic [1:0]       rx;
  logic [PM_W:0]    cand     [NUM_STATES];
  logic             dec      [NUM_STATES];
  logic [PM_W:0]    cand_min;
  logic [1:0]       best;
  logic [PM_W-1:0]  pm_nxt   [NUM_STATES];
  logic [DEPTH-1:0] surv_nxt [NUM_STATES];
  logic [1:0]       ns_idx;

  assign rx = {g0_q, in_i};

  // New state ns = (b, s1); its predecessors are (s1, 0) and (s1, 1).
  for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
    localparam logic [1:0] Ns = 2'(ns);
    localparam logic [1:0] P0 = {Ns[0], 1'b0};
    localparam logic [1:0] P1 = {Ns[0], 1'b1};
    vit_acs #(
      .PM_W(PM_W)
    ) u_acs (
      .pm0_i (pm_q[P0]),
      .pm1_i (pm_q[P1]),
      .bm0_i (hamming2(rx, expected_sym(P0, Ns[1]))),
      .bm1_i (hamming2(rx, expected_sym(P1, Ns[1]))),
      .cand_o(cand[ns]),
      .dec_o (dec[ns])
    );
  end

  always_comb begin
    cand_min = cand[0];
    best     = 2'd0;
    for (int i = 1; i < NUM_STATES; i++) begin
      if (cand[i] < cand_min) begin
        cand_min = cand[i];
        best     = 2'(i);
      end
    end
  end

  always_comb begin
    ns_idx = 2'd0;
    for (int i = 0; i < NUM_STATES; i++) begin
      ns_idx      = 2'(i);
      pm_nxt[i]   = PM_W'(cand[i] - cand_min);
      surv_nxt[i] = {surv_q[{ns_idx[0], dec[i]}][DEPTH-2:0], ns_idx[1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q     <= 1'b0;
      g0_q        <= 1'b0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_W'(INIT_PM);
        surv_q[i] <= '0;
      end
    end else if (sync_i) begin
      phase_q     <= 1'b0;
      g0_q        <= 1'b0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_W'(INIT_PM);
        surv_q[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      if (in_valid_i) begin
        if (!phase_q) begin
          g0_q    <= in_i;
          phase_q <= 1'b1;
        end else begin
          phase_q <= 1'b0;
          for (int i = 0; i < NUM_STATES; i++) begin
            pm_q[i]   <= pm_nxt[i];
            surv_q[i] <= surv_nxt[i];
          end
          out_q       <= surv_nxt[best][DEPTH-1];
          out_valid_q <= (cnt_q >= CNT_W'(DEPTH - 1));
          if (cnt_q != CNT_W'(DEPTH)) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_vdecoder.sv
// Bench for vdecoder: directed frames plus randomised noisy traffic, checked every cycle
// against a forward-enumeration Viterbi model.
module tb_vdecoder;

  localparam int unsigned DEPTH   = 15;
  localparam int unsigned PM_W    = 4;
  localparam int unsigned INIT_PM = 4;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic sync_i;
  logic in_valid_i;
  logic in_i;
  logic out_valid_o;
  logic out_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  vdecoder #(
    .DEPTH  (DEPTH),
    .PM_W   (PM_W),
    .INIT_PM(INIT_PM)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .sync_i     (sync_i),
    .in_valid_i (in_valid_i),
    .in_i       (in_i),
    .out_valid_o(out_valid_o),
    .out_o      (out_o)
  );

  // ---------------- reference model ----------------
  int          mpm [4];
  logic [63:0] msv [4];
  int          mcnt;
  bit          mphase;
  bit          mg0;
  bit          exp_out;
  bit          exp_ov;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mpm[i] = (i == 0) ? 0 : INIT_PM;
      msv[i] = '0;
    end
    mcnt = 0; mphase = 0; mg0 = 0; exp_out = 0; exp_ov = 0;
  endtask

  // Enumerate every (old state, input bit) transition; strict '<' keeps the
  // lower-numbered predecessor on ties because old states are visited in order.
  task automatic model_pair(input bit r0, input bit r1);
    int          npm [4];
    logic [63:0] nsv [4];
    int          mn;
    int          bst;
    for (int i = 0; i < 4; i++) begin
      npm[i] = 1 << 30;
      nsv[i] = '0;
    end
    for (int os = 0; os < 4; os++) begin
      for (int b = 0; b < 2; b++) begin
        int s1, s2, e0, e1, ns, c;
        s1 = os >> 1;
        s2 = os & 1;
        e0 = b ^ s1 ^ s2;
        e1 = b ^ s1;
        ns = b * 2 + s1;
        c  = mpm[os] + ((e0 != int'(r0)) ? 1 : 0) + ((e1 != int'(r1)) ? 1 : 0);
        if (c < npm[ns]) begin
          npm[ns] = c;
          nsv[ns] = (msv[os] << 1) | 64'(b);
        end
      end
    end
    mn = npm[0]; bst = 0;
    for (int i = 1; i < 4; i++) begin
      if (npm[i] < mn) begin
        mn = npm[i]; bst = i;
      end
    end
    exp_out = nsv[bst][DEPTH-1];
    exp_ov  = (mcnt >= DEPTH - 1);
    if (mcnt < DEPTH) mcnt++;
    for (int i = 0; i < 4; i++) begin
      mpm[i] = npm[i] - mn;
      msv[i] = nsv[i];
    end
  endtask

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || sync_i) begin
      model_reset();
    end else begin
      exp_ov = 0;
      if (in_valid_i) begin
        if (!mphase) begin
          mg0 = in_i; mphase = 1;
        end else begin
          mphase = 0;
          model_pair(mg0, in_i);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;

  always @(negedge clk_i) begin
    if (chk_en && rst_ni) begin
      checks++;
      if (out_valid_o !== exp_ov) begin
        errors++;
        $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid_o, exp_ov);
      end
      if (exp_ov) begin
        checks++;
        if (out_o !== exp_out) begin
          errors++;
          $display("FAIL out t=%0t got %b want %b", $time, out_o, exp_out);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (int'(dut.pm_q[i]) != mpm[i] || mpm[i] >= (1 << PM_W)) begin
          errors++;
          $display("FAIL pm[%0d] t=%0t got %0d want %0d", i, $time, dut.pm_q[i], mpm[i]);
        end
      end
    end
  end

  bit dec_q[$];
  always @(negedge clk_i) begin
    if (out_valid_o) dec_q.push_back(out_o);
  end

  // ---------------- stimulus helpers ----------------
  bit es1, es2;
  bit golden[9] = '{0, 1, 1, 1, 0, 1, 0, 0, 0};

  task automatic cyc(input logic v, input logic b, input logic s);
    in_valid_i = v; in_i = b; sync_i = s;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_info(input bit b, input bit f0, input bit f1, input int gmin,
                           input int gmax);
    bit g0, g1;
    g0 = b ^ es1 ^ es2;
    g1 = b ^ es1;
    es2 = es1; es1 = b;
    idle(int'($urandom_range(gmax, gmin)));
    cyc(1'b1, g0 ^ f0, 1'b0);
    idle(int'($urandom_range(gmax, gmin)));
    cyc(1'b1, g1 ^ f1, 1'b0);
  endtask

  task automatic do_sync();
    cyc(1'b0, 1'b0, 1'b1);
    idle(2);
    dec_q.delete();
    es1 = 0; es2 = 0;
  endtask

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Golden frame (9 info bits + DEPTH tail zeros); err_pair flips G1 of that pair.
  task automatic run_frame(input string tag, input int err_pair, input int gmin,
                           input int gmax);
    for (int k = 0; k < 9 + DEPTH; k++) begin
      send_info((k < 9) ? golden[k] : 1'b0, 1'b0, (k == err_pair), gmin, gmax);
      if (k == DEPTH - 2) begin
        idle(1);
        check_eq({tag, "_no_early_valid"}, dec_q.size(), 0);
      end
      if (k == DEPTH - 1) begin
        idle(1);
        check_eq({tag, "_first_valid"}, dec_q.size(), 1);
      end
    end
    idle(2);
    check_eq({tag, "_count"}, dec_q.size(), 9 + DEPTH - (DEPTH - 1));
    for (int i = 0; i < 9; i++) begin
      if (i < dec_q.size()) check_eq({tag, "_bit"}, int'(dec_q[i]), int'(golden[i]));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nz;
    rst_ni = 1'b0; sync_i = 1'b0; in_valid_i = 1'b0; in_i = 1'b0;
    es1 = 0; es2 = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("rst_out", int'(out_o), 0);
    check_eq("rst_out_valid", int'(out_valid_o), 0);
    check_eq("rst_pm0", int'(dut.pm_q[0]), 0);
    check_eq("rst_pm3", int'(dut.pm_q[3]), INIT_PM);
    rst_ni = 1'b1;
    chk_en = 1;
    idle(2);

    run_frame("clean", -1, 0, 0);
    do_sync();
    run_frame("err", 3, 0, 0);
    do_sync();
    run_frame("gap", -1, 1, 5);

    // sync arrives with a valid bit right after the G0 of pair 4
    do_sync();
    for (int k = 0; k < 4; k++) send_info(golden[k], 1'b0, 1'b0, 0, 0);
    cyc(1'b1, golden[4] ^ es1 ^ es2, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    idle(2);
    dec_q.delete();
    es1 = 0; es2 = 0;
    run_frame("sync_mid", -1, 0, 0);

    // asynchronous reset between clock edges, mid-frame
    do_sync();
    for (int k = 0; k < 20; k++) send_info((k < 9) ? golden[k] : 1'b0, 1'b0, 1'b0, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("arst_out_valid", int'(out_valid_o), 0);
    check_eq("arst_out", int'(out_o), 0);
    check_eq("arst_cnt", int'(dut.cnt_q), 0);
    check_eq("arst_pm1", int'(dut.pm_q[1]), INIT_PM);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(2);
    dec_q.delete();
    es1 = 0; es2 = 0;
    run_frame("after_arst", -1, 0, 0);

    // 40 zero info bits then 30 ones
    do_sync();
    for (int k = 0; k < 70; k++) send_info(k >= 40, 1'b0, 1'b0, 0, 0);
    idle(2);
    check_eq("zo_count", dec_q.size(), 70 - (DEPTH - 1));
    nz = 0;
    for (int i = 0; i < dec_q.size(); i++) if (dec_q[i] == 1'b0) nz++;
    check_eq("zo_zeros", nz, 40);
    if (dec_q.size() > 40) check_eq("zo_first_one", int'(dec_q[40]), 1);

    // random noisy traffic with gaps and occasional syncs
    do_sync();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(99) == 0) begin
        if ($urandom_range(1) == 1) cyc(1'b1, 1'(($urandom_range(1))), 1'b0);
        do_sync();
      end
      send_info(1'($urandom_range(1)), ($urandom_range(15) == 0), ($urandom_range(15) == 0),
                0, 2);
    end
    idle(3);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
